// File: rtl/mdu_e.sv
// mdu_e: execute-stage multiply/divide unit. Owns the architectural HI/LO registers.
// Latency: a start computes the result at once but holds busy for MULT_CYCLES or
//   DIV_CYCLES. HI/LO update on the edge where busy falls.
// Backpressure: busy/md_active drive the hazard unit's stall. All md_op values are
//   ignored while busy.
// Ports: clk, reset (sync, active-high); md_op[2:0] E-stage op; rs_val/rt_val operands;
//   busy (registered); md_active (comb stall term); hi_out/lo_out (current HI/LO).
module mdu_e #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  md_op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic        busy,
  output logic        md_active,
  output logic [31:0] hi_out,
  output logic [31:0] lo_out
);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);

  // busy_q doubles as the IDLE(0)/RUN(1) state bit.
  logic          busy_q, busy_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [63:0]   pend_q, pend_d;
  logic          commit_q, commit_d;  // cleared for divide-by-zero so HI/LO are kept
  logic [31:0]   hi_q, hi_d;
  logic [31:0]   lo_q, lo_d;

  logic          is_start;
  logic [63:0]   prod_s, prod_u;
  logic [31:0]   abs_a, abs_b, div_den, uq, ur, sq, sr, dq, dr;

  assign is_start = (md_op == OP_MULT) || (md_op == OP_MULTU) ||
                    (md_op == OP_DIV)  || (md_op == OP_DIVU);

  // Arithmetic datapath, evaluated every cycle and only captured on a start.
  always_comb begin
    prod_s  = $signed({{32{rs_val[31]}}, rs_val}) * $signed({{32{rt_val[31]}}, rt_val});
    prod_u  = {32'd0, rs_val} * {32'd0, rt_val};
    // Signed divide goes through magnitudes, which keeps 0x80000000 / -1
    // well defined: |0x80000000| is 0x80000000 as an unsigned value.
    abs_a   = rs_val[31] ? (32'd0 - rs_val) : rs_val;
    abs_b   = rt_val[31] ? (32'd0 - rt_val) : rt_val;
    div_den = (abs_b == 32'd0) ? 32'd1 : abs_b;
    uq      = abs_a / div_den;
    ur      = abs_a % div_den;
    sq      = (rs_val[31] ^ rt_val[31]) ? (32'd0 - uq) : uq;
    sr      = rs_val[31] ? (32'd0 - ur) : ur;
    dq      = rs_val / ((rt_val == 32'd0) ? 32'd1 : rt_val);
    dr      = rs_val % ((rt_val == 32'd0) ? 32'd1 : rt_val);
  end

  always_comb begin
    busy_d   = busy_q;
    cnt_d    = cnt_q;
    pend_d   = pend_q;
    commit_d = commit_q;
    hi_d     = hi_q;
    lo_d     = lo_q;

    if (busy_q) begin
      if (cnt_q == CW'(1)) begin
        busy_d = 1'b0;
        cnt_d  = '0;
        if (commit_q) begin
          hi_d = pend_q[63:32];
          lo_d = pend_q[31:0];
        end
      end else begin
        cnt_d = cnt_q - CW'(1);
      end
    end else begin
      unique case (md_op)
        OP_MULT: begin
          pend_d   = prod_s;
          commit_d = 1'b1;
          cnt_d    = CW'(MULT_CYCLES);
          busy_d   = 1'b1;
        end
        OP_MULTU: begin
          pend_d   = prod_u;
          commit_d = 1'b1;
          cnt_d    = CW'(MULT_CYCLES);
          busy_d   = 1'b1;
        end
        OP_DIV: begin
          pend_d   = {sr, sq};
          commit_d = (rt_val != 32'd0);
          cnt_d    = CW'(DIV_CYCLES);
          busy_d   = 1'b1;
        end
        OP_DIVU: begin
          pend_d   = {dr, dq};
          commit_d = (rt_val != 32'd0);
          cnt_d    = CW'(DIV_CYCLES);
          busy_d   = 1'b1;
        end
        OP_MTHI: hi_d = rs_val;
        OP_MTLO: lo_d = rs_val;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q   <= 1'b0;
      cnt_q    <= '0;
      pend_q   <= '0;
      commit_q <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      busy_q   <= busy_d;
      cnt_q    <= cnt_d;
      pend_q   <= pend_d;
      commit_q <= commit_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  assign busy      = busy_q;
  assign md_active = busy_q | is_start;
  assign hi_out    = hi_q;
  assign lo_out    = lo_q;

endmodule
